// File: rtl/l2_mem_arbiter_if.sv
// Bundles the I-cache, D-cache and memory-side block signals of the L2 memory arbiter.
// master is the arbiter's view; slave is the caches' and memory's view.
interface l2_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 128
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        input  i_read, i_addr,
        output i_rdata, i_ready,
        input  d_read, d_write, d_addr, d_wdata,
        output d_rdata, d_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        output i_read, i_addr,
        input  i_rdata, i_ready,
        output d_read, d_write, d_addr, d_wdata,
        input  d_rdata, d_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/l2_mem_arbiter.sv
// Round-robin arbiter sharing one block memory port between the L2 I-cache and D-cache.
// One transaction at a time; every output is registered.
module l2_mem_arbiter #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset,
    l2_mem_arbiter_if.master  bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    logic [1:0]        state,       state_nxt;
    logic              last_grant,  last_grant_nxt;
    logic              mem_read_q,  mem_read_nxt;
    logic              mem_write_q, mem_write_nxt;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_nxt;
    logic              i_ready_q,   i_ready_nxt;
    logic              d_ready_q,   d_ready_nxt;
    logic [DATA_W-1:0] i_rdata_q,   i_rdata_nxt;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_nxt;

    logic i_req_c;
    logic d_req_c;

    assign i_req_c = bus.i_read;
    assign d_req_c = bus.d_read | bus.d_write;

    // State register and registered outputs
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state       <= IDLE;
            last_grant  <= GNT_I;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state       <= state_nxt;
            last_grant  <= last_grant_nxt;
            mem_read_q  <= mem_read_nxt;
            mem_write_q <= mem_write_nxt;
            mem_addr_q  <= mem_addr_nxt;
            mem_wdata_q <= mem_wdata_nxt;
            i_ready_q   <= i_ready_nxt;
            d_ready_q   <= d_ready_nxt;
            i_rdata_q   <= i_rdata_nxt;
            d_rdata_q   <= d_rdata_nxt;
        end
    end

    // Next-state, grant decision and next output values
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        mem_read_nxt   = mem_read_q;
        mem_write_nxt  = mem_write_q;
        mem_addr_nxt   = mem_addr_q;
        mem_wdata_nxt  = mem_wdata_q;
        i_ready_nxt    = 1'b0;
        d_ready_nxt    = 1'b0;
        i_rdata_nxt    = i_rdata_q;
        d_rdata_nxt    = d_rdata_q;

        case (state)
            IDLE: begin
                // On a tie the port that did not win last time goes first
                if (i_req_c && (!d_req_c || last_grant == GNT_D)) begin
                    state_nxt      = BUSY_I;
                    last_grant_nxt = GNT_I;
                    mem_read_nxt   = 1'b1;
                    mem_write_nxt  = 1'b0;
                    mem_addr_nxt   = bus.i_addr;
                    mem_wdata_nxt  = '0;
                end else if (d_req_c) begin
                    state_nxt      = BUSY_D;
                    last_grant_nxt = GNT_D;
                    mem_read_nxt   = !bus.d_write;
                    mem_write_nxt  = bus.d_write;
                    mem_addr_nxt   = bus.d_addr;
                    mem_wdata_nxt  = bus.d_write ? bus.d_wdata : '0;
                end
            end
            BUSY_I: begin
                if (bus.mem_ready) begin
                    state_nxt     = RESP;
                    mem_read_nxt  = 1'b0;
                    mem_write_nxt = 1'b0;
                    i_ready_nxt   = 1'b1;
                    i_rdata_nxt   = bus.mem_rdata;
                end
            end
            BUSY_D: begin
                if (bus.mem_ready) begin
                    state_nxt     = RESP;
                    mem_read_nxt  = 1'b0;
                    mem_write_nxt = 1'b0;
                    d_ready_nxt   = 1'b1;
                    if (mem_read_q) begin
                        d_rdata_nxt = bus.mem_rdata;
                    end
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_ready   = i_ready_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Directed bench for l2_mem_arbiter: table of single transactions plus hand-written
// sequences for reset, ties/fairness and stray memory completions.
module tb_l2_mem_arbiter;

    localparam int unsigned AW = 28;
    localparam int unsigned DW = 128;

    logic clk;
    logic proc_reset;

    l2_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    l2_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_run;
    int n_fail;

    typedef struct {
        logic          i_read;
        logic [AW-1:0] i_addr;
        logic          d_read;
        logic          d_write;
        logic [AW-1:0] d_addr;
        logic [DW-1:0] d_wdata;
        int            lat;
        logic [DW-1:0] rdata;
        logic          drop_early;
        logic          exp_rd;
        logic          exp_wr;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata;
        logic          exp_d;
        logic [DW-1:0] exp_i_rdata;
        logic [DW-1:0] exp_d_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] want);
        n_run++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic clear_req();
        bus.i_read  = 1'b0;
        bus.i_addr  = '0;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".mem_read"},  DW'(bus.mem_read),  '0);
        chk({tag, ".mem_write"}, DW'(bus.mem_write), '0);
        chk({tag, ".mem_addr"},  DW'(bus.mem_addr),  '0);
        chk({tag, ".mem_wdata"}, bus.mem_wdata,      '0);
        chk({tag, ".i_ready"},   DW'(bus.i_ready),   '0);
        chk({tag, ".d_ready"},   DW'(bus.d_ready),   '0);
        chk({tag, ".i_rdata"},   bus.i_rdata,        '0);
        chk({tag, ".d_rdata"},   bus.d_rdata,        '0);
    endtask

    // Starts in IDLE at a negedge; ends in IDLE at a negedge
    task automatic run_vec(input int idx, input vec_t v);
        string t;
        t = $sformatf("vec%0d", idx);
        bus.i_read  = v.i_read;
        bus.i_addr  = v.i_addr;
        bus.d_read  = v.d_read;
        bus.d_write = v.d_write;
        bus.d_addr  = v.d_addr;
        bus.d_wdata = v.d_wdata;
        @(negedge clk);
        chk({t, ".mem_read"},  DW'(bus.mem_read),  DW'(v.exp_rd));
        chk({t, ".mem_write"}, DW'(bus.mem_write), DW'(v.exp_wr));
        chk({t, ".mem_addr"},  DW'(bus.mem_addr),  DW'(v.exp_addr));
        chk({t, ".mem_wdata"}, bus.mem_wdata,      v.exp_wdata);
        chk({t, ".early_rdy"}, DW'({bus.i_ready, bus.d_ready}), '0);
        if (v.drop_early) clear_req();
        for (int k = 0; k < v.lat; k++) begin
            @(negedge clk);
            chk({t, ".hold_strobe"}, DW'({bus.mem_read, bus.mem_write}), DW'({v.exp_rd, v.exp_wr}));
            chk({t, ".hold_addr"},   DW'(bus.mem_addr), DW'(v.exp_addr));
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = v.rdata;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        chk({t, ".i_ready"}, DW'(bus.i_ready), DW'(!v.exp_d));
        chk({t, ".d_ready"}, DW'(bus.d_ready), DW'(v.exp_d));
        chk({t, ".i_rdata"}, bus.i_rdata, v.exp_i_rdata);
        chk({t, ".d_rdata"}, bus.d_rdata, v.exp_d_rdata);
        chk({t, ".strobe_clr"}, DW'({bus.mem_read, bus.mem_write}), '0);
        clear_req();
        @(negedge clk);
        chk({t, ".rdy_single"}, DW'({bus.i_ready, bus.d_ready}), '0);
        chk({t, ".no_regrant"}, DW'({bus.mem_read, bus.mem_write}), '0);
        chk({t, ".i_rdata_hold"}, bus.i_rdata, v.exp_i_rdata);
    endtask

    task automatic do_reset();
        @(negedge clk);
        proc_reset = 1'b1;
        @(negedge clk);
        proc_reset = 1'b0;
        @(negedge clk);
    endtask

    logic [DW-1:0] a5;
    logic [DW-1:0] x5a;
    logic [DW-1:0] pat;

    initial begin
        n_run  = 0;
        n_fail = 0;
        a5  = {16{8'hA5}};
        x5a = {16{8'h5A}};
        pat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

        //          i_rd i_addr         d_rd d_wr d_addr        d_wdata        lat rdata          drop  rd   wr   addr           wdata          D    i_rdata d_rdata
        vecs[0] = '{1'b1, 28'h0000040, 1'b0, 1'b0, 28'h0,       '0,            4, a5,            1'b0, 1'b1, 1'b0, 28'h0000040, '0,            1'b0, a5,  '0};
        vecs[1] = '{1'b0, 28'h0,       1'b0, 1'b1, 28'h0000100, 128'h1234,     2, 128'hDEAD,     1'b0, 1'b0, 1'b1, 28'h0000100, 128'h1234,     1'b1, a5,  '0};
        vecs[2] = '{1'b0, 28'h0,       1'b1, 1'b0, 28'h0000200, 128'hFFFF,     1, x5a,           1'b0, 1'b1, 1'b0, 28'h0000200, '0,            1'b1, a5,  x5a};
        vecs[3] = '{1'b0, 28'h0,       1'b1, 1'b1, 28'h0000300, 128'hCAFE,     3, 128'hBEEF,     1'b0, 1'b0, 1'b1, 28'h0000300, 128'hCAFE,     1'b1, a5,  x5a};
        vecs[4] = '{1'b1, 28'hFFFFFFF, 1'b0, 1'b0, 28'h0,       '0,            0, pat,           1'b1, 1'b1, 1'b0, 28'hFFFFFFF, '0,            1'b0, pat, x5a};
        vecs[5] = '{1'b0, 28'h0,       1'b1, 1'b0, 28'h0000000, '0,            0, 128'h1,        1'b0, 1'b1, 1'b0, 28'h0000000, '0,            1'b1, pat, 128'h1};

        proc_reset    = 1'b1;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        clear_req();
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        proc_reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Stray memory completions while idle
        bus.mem_ready = 1'b1;
        bus.mem_rdata = {16{8'hEE}};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stray.ready",  DW'({bus.i_ready, bus.d_ready}), '0);
            chk("stray.strobe", DW'({bus.mem_read, bus.mem_write}), '0);
            chk("stray.d_rdata", bus.d_rdata, 128'h1);
        end
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;

        // Tie after reset, then continuous dual demand: D,I,D,I,D,I
        do_reset();
        bus.i_read = 1'b1;
        bus.i_addr = 28'h0000111;
        bus.d_read = 1'b1;
        bus.d_addr = 28'h0000222;
        for (int t = 0; t < 6; t++) begin
            int  w;
            logic want_d;
            want_d = (t % 2 == 0);
            w = 0;
            while (!(bus.mem_read || bus.mem_write) && w < 10) begin
                @(negedge clk);
                w++;
            end
            chk($sformatf("tie%0d.granted", t), DW'(w < 10), DW'(1'b1));
            if (t == 0) chk("tie0.latency", DW'(w), DW'(1));
            chk($sformatf("tie%0d.addr", t), DW'(bus.mem_addr),
                want_d ? DW'(28'h0000222) : DW'(28'h0000111));
            bus.mem_ready = 1'b1;
            bus.mem_rdata = DW'(t + 16);
            @(negedge clk);
            bus.mem_ready = 1'b0;
            bus.mem_rdata = '0;
            chk($sformatf("tie%0d.i_ready", t), DW'(bus.i_ready), DW'(!want_d));
            chk($sformatf("tie%0d.d_ready", t), DW'(bus.d_ready), DW'(want_d));
        end
        clear_req();
        @(negedge clk);
        @(negedge clk);

        // Asynchronous reset in the middle of a D write
        bus.d_write = 1'b1;
        bus.d_addr  = 28'h0000500;
        bus.d_wdata = 128'h77;
        @(negedge clk);
        chk("rstmid.mem_write", DW'(bus.mem_write), DW'(1'b1));
        @(negedge clk);
        #2;
        proc_reset = 1'b1;
        #1;
        chk_all_zero("rstmid");
        @(negedge clk);
        clear_req();
        proc_reset = 1'b0;
        @(negedge clk);
        bus.i_read = 1'b1;
        bus.i_addr = 28'h0000040;
        @(negedge clk);
        chk("postrst.mem_read",  DW'(bus.mem_read),  DW'(1'b1));
        chk("postrst.mem_write", DW'(bus.mem_write), '0);
        chk("postrst.mem_addr",  DW'(bus.mem_addr),  DW'(28'h0000040));
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 128'h77;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        chk("postrst.i_ready", DW'(bus.i_ready), DW'(1'b1));
        chk("postrst.d_ready", DW'(bus.d_ready), '0);
        chk("postrst.i_rdata", bus.i_rdata, 128'h77);
        clear_req();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
